udp_txbuf_writer: RTL and testbench
===================================

// Module: udp_txbuf_writer
// PURPOSE
//  CPU-side hardware writer for the shared UDP TX buffer; the ROS2 core reads this buffer.
//  - Takes a destination header plus a byte-stream payload.
//  - Waits for the CPU grant from the UDP TX buffer arbiter.
//  - Packs payload bytes into 32-bit words, writes payload first, then the two header words.
//  - Ends each datagram with a one-cycle release pulse that hands the buffer to the ROS2 core.
// PARAMETERS
//  AWIDTH    9   txbuf word-address width
//  MAX_BYTES 4*((1<<AWIDTH)-2)   payload byte capacity (words 2..2^AWIDTH-1)
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       asynchronous active-low reset
//  s_hdr_valid      in   1       datagram header valid
//  s_hdr_ready      out  1       header accepted (1-cycle, IDLE only)
//  s_hdr_dest_ip    in   32      destination IPv4, network byte order
//  s_hdr_dest_port  in   16      destination UDP port
//  s_axis_tdata     in   8       payload byte
//  s_axis_tvalid    in   1       payload byte valid
//  s_axis_tready    out  1       payload byte accepted
//  s_axis_tlast     in   1       last payload byte
//  cpu_grant        in   1       TX buffer granted to CPU side (level)
//  cpu_rel          out  1       release pulse to arbiter (1 cycle)
//  txbuf_addr       out  AWIDTH  buffer word address
//  txbuf_ce         out  1       buffer enable
//  txbuf_we         out  1       buffer write enable
//  txbuf_wdata      out  32      buffer write data
//  busy             out  1       high in any state other than IDLE
//  err_trunc        out  1       1-cycle pulse: payload exceeded MAX_BYTES
//  err_abort        out  1       1-cycle pulse: grant lost mid-datagram
// BEHAVIOUR
//  Reset values and register timing
//  - All outputs reset to 0; state IDLE; byte and word counters 0.
//  - All outputs are registered. Header and payload handshakes complete only when valid and ready are both high on the same edge.
//  Buffer layout
//  - word0 = dest_ip.
//  - word1 = {dest_port, len[15:0]}; len = payload bytes written.
//  - word2.. = payload. Byte k goes to word 2+k/4, lane [8*(k%4)+7 : 8*(k%4)].
//  State machine
//  - IDLE: s_hdr_ready=1. On header handshake: latch ip and port, clear counters, go to WAIT_GRANT.
//  - WAIT_GRANT: s_axis_tready=0. Go to PAYLOAD on cpu_grant=1.
//  - PAYLOAD: s_axis_tready=cpu_grant. On each accepted byte, place it in the pack register and increment the byte count.
//    - 4th byte of a word, or tlast: next cycle ce=we=1, addr=2+word index, wdata=packed word with unused lanes zeroed. The word index then increments.
//    - No stall: throughput is 1 byte/cycle.
//    - Accepted tlast goes to HDR0 after the final word write.
//  - HDR0: one write, addr 0, data = ip. Then HDR1.
//  - HDR1: one write, addr 1, data = {port, len}. Then REL.
//  - REL: cpu_rel=1 for exactly 1 cycle. Then IDLE.
//  - DROP: s_axis_tready=1. Discard bytes until an accepted tlast, then go to IDLE. No writes, no release.
//  Boundaries
//  - Byte count == MAX_BYTES and a non-tlast byte arrives:
//    - byte is discarded and err_trunc pulses once;
//    - keep accepting and discarding until tlast;
//    - len = MAX_BYTES; header words and release proceed normally.
//  - tlast on a byte that fills a word exactly: no extra zero word is written.
//  - cpu_grant falls during PAYLOAD, HDR0 or HDR1:
//    - no write that cycle and no cpu_rel;
//    - err_abort pulses;
//    - go to DROP if tlast is not yet accepted, else to IDLE.
//  - s_hdr_valid outside IDLE is ignored (ready=0). Payload bytes before a header stay blocked (ready=0).
//  - Async reset mid-datagram: immediate return to IDLE with all outputs 0 and no release. The arbiter keeps the grant with the CPU side.
//  - len and counters use 16-bit arithmetic. Word index is AWIDTH bits and never wraps, because the truncation rule caps it.
// TESTING
//  - Header ip=C0A80102 port=1234, 5 bytes 01..05, grant high:
//    writes addr2=04030201, addr3=00000005, addr0=C0A80102, addr1=12340005;
//    then exactly one cpu_rel pulse.
//  - Header, then grant withheld 20 cycles: tready=0 and no writes throughout.
//    Raise grant: writes and release follow as above.
//  - 8-byte payload: exactly 2 payload writes, none at addr4; len=0008.
//  - AWIDTH=3, 30-byte payload: 24 bytes written (addr2..7);
//    err_trunc pulses once; len=0018; release issued.
//  - Drop grant after 3 bytes of 10: err_abort pulses; remaining bytes drained;
//    no cpu_rel; next datagram completes normally.
//  - Assert rst_n low mid-payload: all outputs 0 immediately; busy=0; a fresh header is accepted after reset.

Source files
------------

// File: rtl/udp_txbuf_writer.sv
// Purpose : CPU-side writer for the shared UDP TX buffer. Packs a byte-stream payload into
//           32-bit words (payload first), then writes the two header words and releases the buffer.
// Latency : each payload word is written the cycle after its 4th (or last) byte is accepted; header
//           words follow on consecutive cycles after the final payload word; release pulse one cycle later.
// Backpressure: s_hdr_ready only while idle; s_axis_tready follows cpu_grant in PAYLOAD (1 byte/cycle,
//           never stalls); a lost grant drains the rest of the datagram with tready held high.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_hdr_valid/ready              header handshake, with s_hdr_dest_ip (32b) and s_hdr_dest_port (16b)
//   s_axis_tdata/tvalid/tready/tlast  payload byte stream
//   cpu_grant                      level: TX buffer currently owned by the CPU side
//   cpu_rel                        1-cycle pulse handing the buffer to the ROS2 core
//   txbuf_addr/ce/we/wdata         buffer write port (word addressed)
//   busy                           high whenever a datagram is in progress
//   err_trunc, err_abort           1-cycle error pulses (payload too long / grant lost)
module udp_txbuf_writer #(
  parameter int AWIDTH    = 9,
  parameter int MAX_BYTES = 4 * ((1 << AWIDTH) - 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_hdr_valid,
  output logic              s_hdr_ready,
  input  logic [31:0]       s_hdr_dest_ip,
  input  logic [15:0]       s_hdr_dest_port,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              cpu_grant,
  output logic              cpu_rel,
  output logic [AWIDTH-1:0] txbuf_addr,
  output logic              txbuf_ce,
  output logic              txbuf_we,
  output logic [31:0]       txbuf_wdata,
  output logic              busy,
  output logic              err_trunc,
  output logic              err_abort
);

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } hdr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_PAYLOAD,
    S_HDR0,
    S_HDR1,
    S_REL,
    S_DROP
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  state_t            state;
  hdr_t              hdr;
  logic [15:0]       byte_cnt;   // payload bytes stored so far (becomes len)
  logic [AWIDTH-1:0] word_idx;   // payload words written so far
  logic [31:0]       pack;       // bytes of the word currently being assembled
  logic              trunc_seen; // err_trunc already reported for this datagram

  logic        byte_acc;
  logic        buf_full;
  logic [1:0]  lane;
  logic [31:0] lane_word;

  assign byte_acc = s_axis_tvalid & s_axis_tready;
  assign buf_full = (byte_cnt == MAX_LEN);
  assign lane     = byte_cnt[1:0];

  // Word as it will look once the incoming byte is merged. Lane 0 starts a
  // fresh word, so lanes above the last byte of a short word read as zero.
  always_comb begin
    lane_word = (lane == 2'd0) ? 32'd0 : pack;
    lane_word[{lane, 3'b000} +: 8] = s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      hdr           <= '0;
      byte_cnt      <= '0;
      word_idx      <= '0;
      pack          <= '0;
      trunc_seen    <= 1'b0;
      s_hdr_ready   <= 1'b0;
      s_axis_tready <= 1'b0;
      cpu_rel       <= 1'b0;
      txbuf_addr    <= '0;
      txbuf_ce      <= 1'b0;
      txbuf_we      <= 1'b0;
      txbuf_wdata   <= '0;
      busy          <= 1'b0;
      err_trunc     <= 1'b0;
      err_abort     <= 1'b0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      txbuf_ce  <= 1'b0;
      txbuf_we  <= 1'b0;
      cpu_rel   <= 1'b0;
      err_trunc <= 1'b0;
      err_abort <= 1'b0;

      case (state)
        S_IDLE: begin
          if (s_hdr_valid && s_hdr_ready) begin
            hdr.ip      <= s_hdr_dest_ip;
            hdr.port    <= s_hdr_dest_port;
            byte_cnt    <= '0;
            word_idx    <= '0;
            pack        <= '0;
            trunc_seen  <= 1'b0;
            s_hdr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_WAIT_GRANT;
          end else begin
            s_hdr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        S_WAIT_GRANT: begin
          if (cpu_grant) begin
            s_axis_tready <= 1'b1;
            state         <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (!cpu_grant) begin
            // Grant lost: nothing is written this cycle. A byte presented with
            // tready high is still consumed; if it was the last one the
            // datagram is over, otherwise drain the remainder.
            err_abort <= 1'b1;
            if (byte_acc && s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              s_hdr_ready   <= 1'b1;
              busy          <= 1'b0;
              state         <= S_IDLE;
            end else begin
              s_axis_tready <= 1'b1;
              state         <= S_DROP;
            end
          end else if (byte_acc) begin
            if (!buf_full) begin
              pack     <= lane_word;
              byte_cnt <= byte_cnt + 16'd1;
              if (lane == 2'd3 || s_axis_tlast) begin
                txbuf_ce    <= 1'b1;
                txbuf_we    <= 1'b1;
                txbuf_addr  <= AWIDTH'(2) + word_idx;
                txbuf_wdata <= lane_word;
                word_idx    <= word_idx + AWIDTH'(1);
              end
            end else if (!trunc_seen) begin
              // Buffer full: bytes past capacity are dropped, reported once.
              err_trunc  <= 1'b1;
              trunc_seen <= 1'b1;
            end
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              state         <= S_HDR0;
            end
          end
        end

        S_HDR0: begin
          if (!cpu_grant) begin
            err_abort   <= 1'b1;
            s_hdr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            txbuf_ce    <= 1'b1;
            txbuf_we    <= 1'b1;
            txbuf_addr  <= AWIDTH'(0);
            txbuf_wdata <= hdr.ip;
            state       <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (!cpu_grant) begin
            err_abort   <= 1'b1;
            s_hdr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            txbuf_ce    <= 1'b1;
            txbuf_we    <= 1'b1;
            txbuf_addr  <= AWIDTH'(1);
            txbuf_wdata <= {hdr.port, byte_cnt};
            state       <= S_REL;
          end
        end

        S_REL: begin
          // Release appears the cycle after the last header write is on the
          // bus, so the core never sees the buffer before it is complete.
          cpu_rel     <= 1'b1;
          s_hdr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        S_DROP: begin
          if (byte_acc && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            s_hdr_ready   <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: begin
          s_axis_tready <= 1'b0;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_txbuf_writer.sv
// Purpose : self-checking bench for udp_txbuf_writer (small buffer: AWIDTH=3, 24-byte capacity).
// Latency : n/a (bench).
// Backpressure: drives valid with random gaps and honours the DUT's ready signals.
module tb_udp_txbuf_writer;

  localparam int AW   = 3;
  localparam int MAXB = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_hdr_valid;
  logic          s_hdr_ready;
  logic [31:0]   s_hdr_dest_ip;
  logic [15:0]   s_hdr_dest_port;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          cpu_grant;
  logic          cpu_rel;
  logic [AW-1:0] txbuf_addr;
  logic          txbuf_ce;
  logic          txbuf_we;
  logic [31:0]   txbuf_wdata;
  logic          busy;
  logic          err_trunc;
  logic          err_abort;

  always #5 clk = ~clk;

  udp_txbuf_writer #(.AWIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_hdr_valid     (s_hdr_valid),
    .s_hdr_ready     (s_hdr_ready),
    .s_hdr_dest_ip   (s_hdr_dest_ip),
    .s_hdr_dest_port (s_hdr_dest_port),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .cpu_grant       (cpu_grant),
    .cpu_rel         (cpu_rel),
    .txbuf_addr      (txbuf_addr),
    .txbuf_ce        (txbuf_ce),
    .txbuf_we        (txbuf_we),
    .txbuf_wdata     (txbuf_wdata),
    .busy            (busy),
    .err_trunc       (err_trunc),
    .err_abort       (err_abort)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int        total;
  int        passed;
  int        failed;
  wr_t       log_q[$];
  int        rel_cnt;
  int        trunc_cnt;
  int        abort_cnt;
  logic [7:0] pay [0:63];

  // Bus monitor: outputs only change on posedge, so sample on negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (txbuf_ce && txbuf_we) log_q.push_back('{a: txbuf_addr, d: txbuf_wdata});
      if (cpu_rel)   rel_cnt++;
      if (err_trunc) trunc_cnt++;
      if (err_abort) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] port);
    int t = 0;
    s_hdr_dest_ip   = ip;
    s_hdr_dest_port = port;
    s_hdr_valid     = 1'b1;
    while (!s_hdr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);  // handshake completes on the posedge just passed
    s_hdr_valid = 1'b0;
    check("hdr_accept", 32'(t < 100), 32'd1);
  endtask

  // Feed bytes pay[0..n-1]. drop_at: drop grant once that many bytes were
  // accepted (-1 = never). stop_at: return early after that many (-1 = never).
  task automatic feed(input int n, input int drop_at, input int stop_at, input bit gaps);
    int k = 0;
    int t = 0;
    bit v;
    bit acc;
    while (k < n && k != stop_at && t < 4000) begin
      if (drop_at >= 0 && k == drop_at) cpu_grant = 1'b0;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tvalid = v;
      s_axis_tdata  = pay[k];
      s_axis_tlast  = (k == n - 1);
      acc = v && s_axis_tready;
      @(negedge clk);
      t++;
      if (acc) k++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("feed_budget", 32'(t < 4000), 32'd1);
  endtask

  task automatic do_dgram(input string tag, input logic [31:0] ip, input logic [15:0] port,
                          input int n, input int drop_at, input int hold, input bit gaps);
    wr_t exp_q[$];
    int  w0 = log_q.size();
    int  r0 = rel_cnt;
    int  tr0 = trunc_cnt;
    int  ab0 = abort_cnt;
    int  viol = 0;
    int  t = 0;
    int  nn;
    int  nw;
    int  a4 = 0;
    logic [31:0] d;

    cpu_grant = (hold == 0);
    send_hdr(ip, port);
    if (hold > 0) begin
      // A second header with different fields must be ignored while busy.
      s_hdr_valid   = 1'b1;
      s_hdr_dest_ip = ~ip;
      for (int i = 0; i < hold; i++) begin
        if (s_axis_tready || txbuf_ce || s_hdr_ready || !busy) viol++;
        @(negedge clk);
      end
      s_hdr_valid   = 1'b0;
      s_hdr_dest_ip = ip;
      check({tag, "_hold_quiet"}, 32'(viol), 32'd0);
      cpu_grant = 1'b1;
    end
    feed(n, drop_at, -1, gaps);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(t < 200), 32'd1);
    repeat (2) @(negedge clk);

    // Reference: byte k lands in word 2+k/4, lane k%4; header words follow.
    if (drop_at >= 0) begin
      nn = drop_at;
      nw = drop_at / 4;
    end else begin
      nn = (n > MAXB) ? MAXB : n;
      nw = (nn + 3) / 4;
    end
    for (int w = 0; w < nw; w++) begin
      d = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < nn) d[8 * j +: 8] = pay[4 * w + j];
      exp_q.push_back('{a: AW'(2 + w), d: d});
    end
    if (drop_at < 0) begin
      exp_q.push_back('{a: AW'(0), d: ip});
      exp_q.push_back('{a: AW'(1), d: {port, 16'(nn)}});
    end

    check({tag, "_nwrites"}, 32'(log_q.size() - w0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (w0 + i < log_q.size()) begin
        check({tag, "_addr"}, 32'(log_q[w0 + i].a), 32'(exp_q[i].a));
        check({tag, "_data"}, log_q[w0 + i].d, exp_q[i].d);
      end
    end
    for (int i = w0; i < log_q.size(); i++)
      if (log_q[i].a == AW'(2 + nw) && nw < 6) a4++;
    check({tag, "_no_extra_word"}, 32'(a4), 32'd0);
    check({tag, "_rel"},   32'(rel_cnt - r0),   (drop_at < 0) ? 32'd1 : 32'd0);
    check({tag, "_trunc"}, 32'(trunc_cnt - tr0), (drop_at < 0 && n > MAXB) ? 32'd1 : 32'd0);
    check({tag, "_abort"}, 32'(abort_cnt - ab0), (drop_at >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    int n;
    total = 0; passed = 0; failed = 0;
    rel_cnt = 0; trunc_cnt = 0; abort_cnt = 0;
    rst_n = 1'b0;
    s_hdr_valid = 1'b0; s_hdr_dest_ip = '0; s_hdr_dest_port = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cpu_grant = 1'b0;
    for (int i = 0; i < 64; i++) pay[i] = 8'(i + 1);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'({s_hdr_ready, s_axis_tready, cpu_rel, txbuf_ce, txbuf_we,
                            busy, err_trunc, err_abort}), 32'd0);
    check("reset_addr", 32'(txbuf_addr), 32'd0);
    check("reset_wdata", txbuf_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hdr_ready", 32'(s_hdr_ready), 32'd1);

    // Payload without a header stays blocked
    s_axis_tvalid = 1'b1;
    cpu_grant     = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tready_blocked", 32'({s_axis_tready, busy, txbuf_ce}), 32'd0);
    s_axis_tvalid = 1'b0;

    // Basic 5-byte datagram with known constants
    do_dgram("basic5", 32'hC0A80102, 16'h1234, 5, -1, 0, 1'b0);
    check("basic5_word2", log_q[log_q.size() - 4].d, 32'h04030201);
    check("basic5_hdr1",  log_q[log_q.size() - 1].d, 32'h12340005);

    // Grant withheld for 20 cycles after the header
    do_dgram("hold20", 32'hC0A80102, 16'h1234, 5, -1, 20, 1'b0);

    // Exactly two words, no trailing zero word
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    do_dgram("exact8", 32'h0A000001, 16'h0050, 8, -1, 0, 1'b1);

    // Truncation: 30 bytes into a 24-byte buffer
    for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
    do_dgram("trunc30", 32'h0A0B0C0D, 16'hBEEF, 30, -1, 0, 1'b1);

    // Grant lost after 3 of 10 bytes, then a normal datagram
    for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
    do_dgram("abort10", 32'h01020304, 16'h0001, 10, 3, 0, 1'b0);
    for (int i = 0; i < 12; i++) pay[i] = 8'($urandom);
    do_dgram("after_abort", 32'h05060708, 16'h0002, 12, -1, 0, 1'b1);

    // Randomized datagrams
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      do_dgram("rand", $urandom, 16'($urandom), n, -1, 0, 1'b1);
    end

    // Asynchronous reset in the middle of the payload
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    cpu_grant = 1'b1;
    send_hdr(32'hDEADBEEF, 16'h4242);
    feed(16, -1, 6, 1'b0);
    r0 = rel_cnt;
    w0 = log_q.size();
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({s_hdr_ready, s_axis_tready, cpu_rel, txbuf_ce, txbuf_we,
                             err_trunc, err_abort}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wdata", txbuf_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_rel", 32'(rel_cnt - r0), 32'd0);
    check("midrst_no_write", 32'(log_q.size() - w0), 32'd0);
    for (int i = 0; i < 7; i++) pay[i] = 8'($urandom);
    do_dgram("post_rst", 32'hC0A80002, 16'h2222, 7, -1, 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
